// File: rtl/btn_pkg.sv
// Shared types and 12 MHz default timing constants for the button conditioning blocks.
package btn_pkg;

   // Debounce / auto-repeat FSM states.
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      DEB_PRESS   = 3'd1,
      HOLD_DELAY  = 3'd2,
      REPEAT      = 3'd3,
      DEB_RELEASE = 3'd4
   } btn_state_e;

   // Defaults for a 12 MHz system clock.
   localparam int DEBOUNCE_10MS     = 120000;   // 10 ms
   localparam int REPEAT_DELAY_0S5  = 6000000;  // 0.5 s
   localparam int REPEAT_PERIOD_DEF = 2097152;  // ~0.175 s

   // Largest of three timing parameters; sizes the shared counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reusable for any board input.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   // Next values: shift the raw input through the two stages.
   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   // Synchroniser flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Synchronises, debounces and auto-repeats one push button; emits one-cycle
// press / release / step pulses in the clk domain.
// `release` is a reserved word in SystemVerilog, so that output is release_pulse.
module button_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_0S5,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press,
   output logic release_pulse,
   output logic step
);

   // One counter serves all timed states; it is cleared on every state change.
   localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             btn_s2;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             step_q, step_d;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_s2)
   );

   // Next-state, counter and pulse decode; pulses default low every cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      step_d    = 1'b0;
      case (state_q)
         IDLE: begin
            level_d = 1'b0;
            cnt_d   = '0;
            if (btn_s2) state_d = DEB_PRESS;
         end
         DEB_PRESS: begin
            if (!btn_s2) begin
               // Bounce rejected before the window closed.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HOLD_DELAY;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
               step_d  = 1'b1;
            end
         end
         HOLD_DELAY: begin
            if (!btn_s2) begin
               state_d = DEB_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == DLY_LAST) begin
               state_d = REPEAT;
               cnt_d   = '0;
               step_d  = 1'b1;
            end
         end
         REPEAT: begin
            // A release seen on the terminal edge wins: no step is issued.
            if (!btn_s2) begin
               state_d = DEB_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == PER_LAST) begin
               cnt_d  = '0;
               step_d = 1'b1;
            end
         end
         DEB_RELEASE: begin
            // Bounces restart the window but never re-enter the hold states.
            if (btn_s2) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs; reset aborts without a release pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         step_q    <= step_d;
      end
   end

   assign btn_level     = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign step          = step_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: expected pulses are queued with the
// clock edge they must appear after, and a negedge monitor pops and compares.
module tb_button_debounce;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk;
   logic rst;
   logic btn_in;
   logic btn_level, press, release_pulse, step;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = -1;   // index of the most recent posedge

   typedef struct {
      int   e;
      logic p;
      logic r;
      logic s;
      logic l;
   } exp_t;

   exp_t exp_q[$];

   button_debounce #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press         (press),
      .release_pulse (release_pulse),
      .step          (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic push_exp(input int e, input logic p, input logic r, input logic s, input logic l);
      exp_t x;
      x.e = e; x.p = p; x.r = r; x.s = s; x.l = l;
      exp_q.push_back(x);
   endtask

   // r: edge at which btn_in is first sampled high for good.
   // first_fall: first edge btn_in is sampled low; the FSM sees it two edges later,
   // so repeat steps can only fire on edges <= first_fall+1.
   task automatic push_cycle(input int r, input int first_fall, input int rel_edge);
      int p;
      p = r + D + 2;
      push_exp(p, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int t = p + RD; t <= first_fall + 1; t += RP)
         push_exp(t, 1'b0, 1'b0, 1'b1, 1'b1);
      push_exp(rel_edge, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Return just after posedge number k; a value driven now is sampled at k+1.
   task automatic goto_edge(input int k);
      while (edge_n < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every expected pulse must appear on its edge, nothing else may pulse.
   always @(negedge clk) begin : mon
      exp_t x;
      if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
         x = exp_q.pop_front();
         check("pulse", 32'({press, release_pulse, step, btn_level}), 32'({x.p, x.r, x.s, x.l}));
      end else if (press || release_pulse || step) begin
         check("spurious_pulse", 32'({press, release_pulse, step}), 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at edge %0d", edge_n);
      $fatal(1);
   end

   initial begin
      int e0, f0, fa, f, rr;
      rst    = 1'b1;
      btn_in = 1'b0;

      // Reset state.
      goto_edge(2);
      @(negedge clk);
      check("rst_level",   32'(btn_level),     32'd0);
      check("rst_press",   32'(press),         32'd0);
      check("rst_release", 32'(release_pulse), 32'd0);
      check("rst_step",    32'(step),          32'd0);
      rst = 1'b0;
      goto_edge(5);

      // Clean press held through three repeats: press +6, steps +16/+19/+22, release f0+6.
      e0 = edge_n + 1;
      f0 = e0 + 23;
      push_cycle(e0, f0, f0 + D + 2);
      btn_in = 1'b1;
      goto_edge(f0 - 1);
      btn_in = 1'b0;
      goto_edge(f0 + 10);
      check("clean_drain", 32'(exp_q.size()), 32'd0);

      // Press bounce: high 3, low 2, then held; timing counts from the final rise.
      e0 = edge_n + 1;
      rr = e0 + 5;
      f0 = rr + 12;
      push_cycle(rr, f0, f0 + D + 2);
      btn_in = 1'b1;
      goto_edge(e0 + 2);
      btn_in = 1'b0;
      goto_edge(e0 + 4);
      btn_in = 1'b1;
      goto_edge(f0 - 1);
      btn_in = 1'b0;
      goto_edge(f0 + 10);
      check("pbounce_drain", 32'(exp_q.size()), 32'd0);

      // Release bounce: low 2, high 1, low held. The re-high is seen by the FSM at
      // edge f+1, which clears cnt; the window then needs D more edges -> release at f+D+1.
      e0 = edge_n + 1;
      fa = e0 + 20;
      f  = fa + 3;
      push_cycle(e0, fa, f + D + 1);
      btn_in = 1'b1;
      goto_edge(fa - 1);
      btn_in = 1'b0;
      goto_edge(fa + 1);
      btn_in = 1'b1;
      goto_edge(fa + 2);
      btn_in = 1'b0;
      goto_edge(f + D);
      @(negedge clk);
      check("rbounce_level_held", 32'(btn_level), 32'd1);
      goto_edge(f + 12);
      check("rbounce_drain", 32'(exp_q.size()), 32'd0);

      // Short tap: past debounce, before first repeat.
      e0 = edge_n + 1;
      f0 = e0 + 10;
      push_cycle(e0, f0, f0 + D + 2);
      btn_in = 1'b1;
      goto_edge(f0 - 1);
      btn_in = 1'b0;
      goto_edge(f0 + 10);
      check("tap_drain", 32'(exp_q.size()), 32'd0);

      // Release seen on the repeat terminal edge e0+19: step there is suppressed.
      e0 = edge_n + 1;
      f0 = e0 + 17;
      push_cycle(e0, f0, f0 + D + 2);
      btn_in = 1'b1;
      goto_edge(f0 - 1);
      btn_in = 1'b0;
      goto_edge(e0 + 20);
      @(negedge clk);
      check("term_level_held", 32'(btn_level), 32'd1);
      goto_edge(f0 + 10);
      check("term_drain", 32'(exp_q.size()), 32'd0);

      // Reset for one cycle while in REPEAT (edge e0+21, between steps at +19 and +22).
      e0 = edge_n + 1;
      push_exp(e0 + D + 2, 1'b1, 1'b0, 1'b1, 1'b1);
      push_exp(e0 + D + 2 + RD, 1'b0, 1'b0, 1'b1, 1'b1);
      push_exp(e0 + D + 2 + RD + RP, 1'b0, 1'b0, 1'b1, 1'b1);
      btn_in = 1'b1;
      goto_edge(e0 + 20);
      rst = 1'b1;
      goto_edge(e0 + 21);
      @(negedge clk);
      check("mid_rst_level",   32'(btn_level),     32'd0);
      check("mid_rst_press",   32'(press),         32'd0);
      check("mid_rst_release", 32'(release_pulse), 32'd0);
      check("mid_rst_step",    32'(step),          32'd0);
      rst = 1'b0;
      rr = e0 + 22;   // first edge with rst low samples the still-high button
      f0 = rr + 20;
      push_cycle(rr, f0, f0 + D + 2);
      goto_edge(f0 - 1);
      btn_in = 1'b0;
      goto_edge(f0 + 10);
      check("mid_rst_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
